// File: rtl/m_frontend_pkg.sv
// Shared types and decode helpers for the PCPI RV32M front end.
// Tag layout, FSM states and the RV32M match rule live here so every file agrees on them.
package m_frontend_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    F3_MUL,
    F3_MULH,
    F3_MULHSU,
    F3_MULHU,
    F3_DIV,
    F3_DIVU,
    F3_REM,
    F3_REMU
  } funct3_e;

  // Result-cache tag: the operation and both operand values (67 bits).
  typedef struct packed {
    funct3_e     funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } tag_t;

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/m_result_cache.sv
// One-entry result cache for the M-unit front end.
// Lookup is combinational; write and invalidate take effect on the next rising edge.
module m_result_cache
  import m_frontend_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  tag_t        lookup_tag_i,
  output logic        hit_o,
  output logic        hit_wr_o,
  output logic [31:0] hit_rd_o,
  input  logic        wr_en_i,
  input  tag_t        wr_tag_i,
  input  logic        wr_wr_i,
  input  logic [31:0] wr_rd_i,
  input  logic        inval_i
);

  logic        valid_q;
  tag_t        tag_q;
  logic        wr_q;
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: tag and payload are deliberately left out of reset; valid_q alone gates
  // every use of them, so resetting the 100-odd payload flops would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q <= wr_tag_i;
      wr_q  <= wr_wr_i;
      rd_q  <= wr_rd_i;
    end
  end

  assign hit_o    = EN && valid_q && (tag_q == lookup_tag_i);
  assign hit_wr_o = wr_q;
  assign hit_rd_o = rd_q;

endmodule

// File: rtl/m_pcpi_frontend.sv
// PicoRV32 PCPI front end for an RV32M unit: decode, one request in flight,
// bounded wait for completion, one-cycle response strobe and a one-entry result cache.
module m_pcpi_frontend
  import m_frontend_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          CACHE_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mu_valid,
  output logic [31:0] mu_insn,
  output logic [31:0] mu_rs1,
  output logic [31:0] mu_rs2,
  input  logic        mu_wr,
  input  logic [31:0] mu_rd,
  input  logic        mu_busy,
  input  logic        mu_ready,
  output logic        timeout_err,
  output logic        cache_hit
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic             wr_q, wr_d;
  logic [31:0]      rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             drop_q, drop_d;
  logic             wait_q, wait_d;
  logic             terr_q, terr_d;

  logic        lk_hit, lk_wr;
  logic [31:0] lk_rd;
  logic        cache_we, cache_inval, drop_now;
  tag_t        lk_tag, wr_tag;
  logic        unused_mu_busy;

  assign unused_mu_busy = mu_busy;

  assign lk_tag = '{funct3: funct3_e'(pcpi_insn[14:12]), rs1: pcpi_rs1, rs2: pcpi_rs2};
  assign wr_tag = '{funct3: funct3_e'(insn_q[14:12]), rs1: rs1_q, rs2: rs2_q};

  m_result_cache #(
    .EN (CACHE_EN)
  ) u_cache (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag_i (lk_tag),
    .hit_o        (lk_hit),
    .hit_wr_o     (lk_wr),
    .hit_rd_o     (lk_rd),
    .wr_en_i      (cache_we),
    .wr_tag_i     (wr_tag),
    .wr_wr_i      (mu_wr),
    .wr_rd_i      (mu_rd),
    .inval_i      (cache_inval)
  );

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the decode can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    insn_d      = insn_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    drop_d      = drop_q;
    terr_d      = terr_q;
    cache_we    = 1'b0;
    cache_inval = 1'b0;
    drop_now    = drop_q | ~pcpi_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (pcpi_valid && is_muldiv(pcpi_insn)) begin
          insn_d = pcpi_insn;
          rs1_d  = pcpi_rs1;
          rs2_d  = pcpi_rs2;
          drop_d = 1'b0;
          hit_d  = lk_hit;
          if (lk_hit) begin
            wr_d    = lk_wr;
            rd_d    = lk_rd;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // The issue cycle is count 0, so the first WAIT cycle already reads 1.
        cnt_d   = CNT_W'(1);
        drop_d  = drop_now;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        drop_d = drop_now;
        if (mu_ready) begin
          wr_d     = mu_wr;
          rd_d     = mu_rd;
          cache_we = 1'b1;
          state_d  = drop_now ? ST_IDLE : ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          wr_d        = 1'b0;
          rd_d        = '0;
          terr_d      = 1'b1;
          cache_inval = 1'b1;
          state_d     = drop_now ? ST_IDLE : ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pcpi_valid) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wait_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_RESP);
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      drop_q  <= 1'b0;
      wait_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      drop_q  <= drop_d;
      wait_q  <= wait_d;
      terr_q  <= terr_d;
    end
  end

  assign pcpi_ready  = (state_q == ST_RESP);
  assign pcpi_wr     = pcpi_ready & wr_q;
  assign pcpi_rd     = pcpi_ready ? rd_q : '0;
  assign pcpi_wait   = wait_q;
  assign cache_hit   = pcpi_ready & hit_q;
  assign mu_valid    = (state_q == ST_ISSUE);
  assign mu_insn     = insn_q;
  assign mu_rs1      = rs1_q;
  assign mu_rs2      = rs2_q;
  assign timeout_err = terr_q;

endmodule
